// File: rtl/alu_sequencer.sv
// alu_sequencer: instruction sequencer for the ALU + accumulator pair.
// Decodes OP/CMP/LDI/REP, applies repeat counts and holds the flags.
module alu_sequencer #(
  parameter int              DATA_W  = 8,
  parameter int              SEL_W   = 4,
  parameter logic [SEL_W-1:0] ADD_SEL = '0
) (
  input  logic              clk,
  input  logic              clb,
  input  logic              instr_valid,
  input  logic [13:0]       instr,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] acc_in,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  output logic              load_acc,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    M_OP  = 2'b00,
    M_CMP = 2'b01,
    M_LDI = 2'b10,
    M_REP = 2'b11
  } mode_t;

  state_t      state_q;
  logic [13:0] ir_q;
  logic [7:0]  rep_q;
  logic [7:0]  iter_q;
  logic        cf_q;
  logic        zf_q;

  mode_t              in_mode;
  mode_t              ir_mode;
  logic [DATA_W-1:0]  ir_imm;
  logic [SEL_W-1:0]   ir_sel;

  assign in_mode = mode_t'(instr[13:12]);
  assign ir_mode = mode_t'(ir_q[13:12]);
  assign ir_imm  = DATA_W'(ir_q[7:0]);
  assign ir_sel  = SEL_W'(ir_q[11:8]);

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign carry_flag  = cf_q;
  assign zero_flag   = zf_q;

  // Operand A follows acc_in live so repeated iterations chain.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_sel  = '0;
    load_acc = 1'b0;
    if (state_q == S_EXEC) begin
      unique case (ir_mode)
        M_OP: begin
          alu_a    = acc_in;
          alu_b    = ir_imm;
          alu_sel  = ir_sel;
          load_acc = 1'b1;
        end
        M_CMP: begin
          alu_a   = acc_in;
          alu_b   = ir_imm;
          alu_sel = ir_sel;
        end
        M_LDI: begin
          alu_a    = ir_imm;
          alu_sel  = ADD_SEL;
          load_acc = 1'b1;
        end
        M_REP: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clb) begin
    if (!clb) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      rep_q   <= '0;
      iter_q  <= '0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            ir_q <= instr;
            if (in_mode == M_REP) begin
              rep_q   <= instr[7:0];
              state_q <= S_DONE;
            end else begin
              iter_q  <= (rep_q == 8'd0) ? 8'd1 : rep_q;
              rep_q   <= '0;
              state_q <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          cf_q   <= alu_carry;
          zf_q   <= alu_zero;
          iter_q <= iter_q - 8'd1;
          if (iter_q <= 8'd1) state_q <= S_DONE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Instruction-driven controller that sequences the ALU + accumulator datapath.
- Accepts 14-bit instructions over a valid/ready handshake and drives the ALU operands, ALU select and the accumulator load strobe.
- Registers the carry and zero flags and supports a repeat prefix, so one ALU op can be applied N times back-to-back (multiply-by-add, shift chains).
- Sits between an instruction source (testbench, ROM reader or host) and the ALU/ACC pair.

Parameters:
- DATA_W, 8, datapath width (ALU operands, accumulator, immediate).
- SEL_W, 4, ALU select width.
- ADD_SEL, 4'b0000, ALU select code for A+B; used by LDI.

Ports:
- clk  input  1  system clock, rising edge.
- clb  input  1  asynchronous active-low reset.
- instr_valid  input  1  instruction present.
- instr  input  14  {mode[13:12], sel[11:8], imm[7:0]}.
- instr_ready  output  1  controller can accept an instruction.
- acc_in  input  DATA_W  current accumulator value (from ACC acc_out).
- alu_carry  input  1  ALU CarryOut.
- alu_zero  input  1  ALU Z.
- alu_a  output  DATA_W  ALU operand A.
- alu_b  output  DATA_W  ALU operand B.
- alu_sel  output  SEL_W  ALU select.
- load_acc  output  1  accumulator load enable.
- carry_flag  output  1  registered carry from the last executed op.
- zero_flag  output  1  registered zero from the last executed op.
- done  output  1  one-cycle pulse when an instruction retires.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Modes:
  - 00 OP: A=acc_in, B=imm, sel=sel; load_acc=1.
  - 01 CMP: same operands as OP; load_acc=0; flags are updated.
  - 10 LDI: A=imm, B=0, sel=ADD_SEL; load_acc=1.
  - 11 REP: rep_cnt<=imm; no ALU activity.
- FSM states are IDLE, EXEC and DONE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr into ir.
  - REP goes to DONE; all other modes go to EXEC with iter_cnt<=(rep_cnt==0 ? 1 : rep_cnt) and rep_cnt<=0.
- EXEC:
  - alu_a/alu_b/alu_sel are driven from ir per mode.
  - load_acc is per mode, asserted for exactly this cycle; the ACC captures at the closing edge.
  - At the same edge: carry_flag<=alu_carry, zero_flag<=alu_zero, iter_cnt<=iter_cnt-1.
  - Stay in EXEC while iter_cnt>1; go to DONE when iter_cnt==1.
  - Consecutive EXEC cycles see the updated acc_in, so results chain.
- DONE:
  - done=1 for one cycle; flags are stable and valid.
  - Next state is IDLE.
- Latency: an accepted non-REP op retires N+1 cycles after acceptance (N iterations + DONE). REP retires 1 cycle after acceptance.
- Outside EXEC: load_acc=0; alu_a, alu_b and alu_sel=0.
- instr_ready=0 in EXEC and DONE. Instructions offered then are held off; the source keeps instr stable while instr_valid is high.
- The REP prefix applies only to the next non-REP instruction.
  - REP followed by REP: the second count overwrites the first.
  - REP imm=0: the next op executes once.
- iter_cnt is 8 bits; REP 255 yields 255 iterations. There is no wrap past zero: the exit check happens at 1.
- Flags are not touched by LDI? No, LDI updates flags like any executed op. REP leaves flags unchanged.
- Reset (clb low, any state, including mid-repeat):
  - State goes to IDLE; ir, rep_cnt and iter_cnt go to 0.
  - carry_flag, zero_flag, done, load_acc and busy go to 0; alu_* go to 0.
  - instr_ready becomes 1 once clb is deasserted.
  - The ACC is reset by the same clb.

Test Plan:
- Reset mid-EXEC of REP 5 + OP ADD: pull clb low during the 3rd iteration -> load_acc=0, busy=0, done=0, flags=0 immediately; after release, instr_ready=1 and rep_cnt is cleared (next OP executes once).
- LDI imm=8'h25 -> one EXEC cycle with alu_a=8'h25, alu_b=0, alu_sel=ADD_SEL, load_acc=1; done in the following cycle; acc=8'h25, zero_flag=0.
- LDI 8'h03, REP 4, OP ADD imm=8'h05 -> four consecutive load_acc cycles; acc steps 03->08->0D->12->17; a single done after the last iteration; busy held for 5 cycles.
- LDI 8'h10, CMP with the ALU subtract code and imm=8'h10 -> load_acc stays 0, acc remains 8'h10, zero_flag=1, carry_flag reflects no borrow.
- LDI 8'hFF, OP ADD imm=8'h01 -> acc=8'h00, carry_flag=1, zero_flag=1; instr_valid held high during EXEC/DONE is not accepted until IDLE.
- REP 0 then OP ADD imm=1 -> exactly one EXEC cycle; REP 3, REP 2, OP -> exactly 2 iterations.
